// File: rtl/instruction_dispatcher_if.sv
// Command/engine/instruction-bus bundle for the instruction dispatcher.
// The slave side is the dispatcher; the master side is the top-level
// sequencer together with the engines it feeds.
interface instruction_dispatcher_if #(
  parameter int NUM_ENGINES = 4,
  parameter int PARAM_W     = 6,
  parameter int INSTR_W     = 21
);
  localparam int EW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

  logic                           cmd_valid_i;
  logic                           cmd_ready_o;
  logic [EW-1:0]                  cmd_engine_i;
  logic [PARAM_W-1:0]             cmd_param_i;
  logic [NUM_ENGINES-1:0]         engine_start_o;
  logic [PARAM_W-1:0]             engine_param_o;
  logic [NUM_ENGINES*INSTR_W-1:0] engine_instr_i;
  logic [NUM_ENGINES-1:0]         engine_done_i;
  logic [INSTR_W-1:0]             instruction_o;
  logic                           busy_o;
  logic                           cmd_done_o;
  logic                           err_timeout_o;
  logic                           err_clr_i;

  modport slave (
    input  cmd_valid_i, cmd_engine_i, cmd_param_i, engine_instr_i,
           engine_done_i, err_clr_i,
    output cmd_ready_o, engine_start_o, engine_param_o, instruction_o,
           busy_o, cmd_done_o, err_timeout_o
  );

  modport master (
    output cmd_valid_i, cmd_engine_i, cmd_param_i, engine_instr_i,
           engine_done_i, err_clr_i,
    input  cmd_ready_o, engine_start_o, engine_param_o, instruction_o,
           busy_o, cmd_done_o, err_timeout_o
  );
endinterface

// File: rtl/instruction_dispatcher.sv
// Instruction dispatcher: queues {engine, param} commands, starts one engine
// at a time, muxes the active engine's word onto the shared instruction bus
// (NOP when idle) and aborts engines that stay busy too long.
module instruction_dispatcher #(
  parameter int NUM_ENGINES = 4,
  parameter int PARAM_W     = 6,
  parameter int INSTR_W     = 21,
  parameter int FIFO_DEPTH  = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  instruction_dispatcher_if.slave bus
);
  localparam int EW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_BUSY} state_t;

  logic [EW+PARAM_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]           r_wptr;
  logic [AW:0]           r_rptr;
  state_t                r_state;
  logic [EW-1:0]         r_active_eng;
  logic [PARAM_W-1:0]    r_active_param;
  logic [CW-1:0]         r_cnt;
  logic                  r_cmd_done;
  logic                  r_err;

  logic [AW:0]            w_fill;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic [31:0]            w_eng_ext;
  logic                   w_eng_ok;
  logic                   w_done_sel;
  logic                   w_done;
  logic                   w_complete;
  logic                   w_timeout;
  logic [INSTR_W-1:0]     w_instr_sel;
  logic [NUM_ENGINES-1:0] w_start;

  // Queue occupancy uses one extra pointer bit to tell full from empty.
  assign w_fill  = r_wptr - r_rptr;
  assign w_full  = (w_fill == (AW+1)'(FIFO_DEPTH));
  assign w_empty = (r_wptr == r_rptr);
  assign w_push  = bus.cmd_valid_i && !w_full;

  // An out-of-range engine index behaves as an engine that finishes instantly.
  assign w_eng_ext  = 32'(r_active_eng);
  assign w_eng_ok   = (w_eng_ext < 32'(NUM_ENGINES));
  assign w_done     = w_eng_ok ? w_done_sel : 1'b1;
  assign w_complete = ((r_state == S_DISPATCH) || (r_state == S_BUSY)) && w_done;
  assign w_timeout  = (r_state == S_BUSY) && !w_done && (r_cnt == CW'(TIMEOUT - 1));
  assign w_pop      = !w_empty && ((r_state == S_IDLE) || w_complete);

  // Select the active engine's done flag, instruction word and start strobe.
  always_comb begin
    w_done_sel  = 1'b0;
    w_instr_sel = '0;
    w_start     = '0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      if (w_eng_ext == 32'(k)) begin
        w_done_sel  = bus.engine_done_i[k];
        w_instr_sel = bus.engine_instr_i[k*INSTR_W +: INSTR_W];
        w_start[k]  = (r_state == S_DISPATCH);
      end
    end
  end

  assign bus.cmd_ready_o    = !w_full;
  assign bus.engine_start_o = w_start;
  assign bus.engine_param_o = r_active_param;
  assign bus.instruction_o  = (r_state != S_IDLE) ? w_instr_sel : '0;
  assign bus.busy_o         = (r_state != S_IDLE) || !w_empty;
  assign bus.cmd_done_o     = r_cmd_done;
  assign bus.err_timeout_o  = r_err;

  // Command storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= {bus.cmd_engine_i, bus.cmd_param_i};
  end

  // Queue pointers; reset empties the queue.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Dispatch FSM with the active command, timeout counter and status flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state        <= S_IDLE;
      r_active_eng   <= '0;
      r_active_param <= '0;
      r_cnt          <= '0;
      r_cmd_done     <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_cmd_done <= w_complete;
      if (w_timeout)          r_err <= 1'b1;
      else if (bus.err_clr_i) r_err <= 1'b0;

      if (w_pop) begin
        r_state                        <= S_DISPATCH;
        {r_active_eng, r_active_param} <= r_mem[r_rptr[AW-1:0]];
        r_cnt                          <= '0;
      end else begin
        case (r_state)
          S_IDLE:     r_state <= S_IDLE;
          S_DISPATCH: begin
            r_cnt   <= '0;
            r_state <= w_complete ? S_IDLE : S_BUSY;
          end
          S_BUSY: begin
            if (w_complete || w_timeout) r_state <= S_IDLE;
            else                         r_cnt   <= r_cnt + 1'b1;
          end
          default:    r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_instruction_dispatcher.sv
// Bench for instruction_dispatcher: directed vector table, hand-written
// multi-cycle corner sequences and randomized traffic against a queue-based
// reference model.
module tb_instruction_dispatcher;
  localparam int NE = 4;
  localparam int PW = 6;
  localparam int IW = 21;
  localparam int FD = 2;
  localparam int TO = 15;

  localparam logic [IW-1:0] W0 = 21'h0A0A0;
  localparam logic [IW-1:0] W1 = 21'h11111;
  localparam logic [IW-1:0] W2 = 21'h02222;
  localparam logic [IW-1:0] W3 = 21'h13333;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instruction_dispatcher_if #(.NUM_ENGINES(NE), .PARAM_W(PW), .INSTR_W(IW)) bus ();

  instruction_dispatcher #(
    .NUM_ENGINES(NE), .PARAM_W(PW), .INSTR_W(IW), .FIFO_DEPTH(FD), .TIMEOUT(TO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0] eng;
    logic [5:0] param;
  } cmd_t;

  cmd_t m_q[$];
  bit   m_active;
  int   m_age;      // cycles since the dispatch cycle of the active command
  cmd_t m_cur;
  bit   m_cdone;
  bit   m_err;

  task automatic model_reset();
    m_q.delete();
    m_active = 1'b0;
    m_age    = 0;
    m_cur    = '0;
    m_cdone  = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic model_step();
    bit done, can_push, freed, tmo;
    cmd_t c;
    done     = m_active && bus.engine_done_i[m_cur.eng];
    can_push = bus.cmd_valid_i && (m_q.size() < FD);
    freed    = !m_active || done;
    tmo      = 1'b0;
    m_cdone  = done;
    if (m_active) begin
      if (done) m_active = 1'b0;
      else if (m_age == TO) begin m_active = 1'b0; tmo = 1'b1; end
      else m_age++;
    end
    if (freed && m_q.size() > 0) begin
      m_cur    = m_q.pop_front();
      m_active = 1'b1;
      m_age    = 0;
    end
    if (tmo) m_err = 1'b1;
    else if (bus.err_clr_i) m_err = 1'b0;
    if (can_push) begin
      c.eng   = bus.cmd_engine_i;
      c.param = bus.cmd_param_i;
      m_q.push_back(c);
    end
  endtask

  task automatic model_compare();
    logic [3:0]    xs;
    logic [IW-1:0] xi;
    xs = (m_active && m_age == 0) ? (4'b0001 << m_cur.eng) : 4'b0000;
    xi = m_active ? bus.engine_instr_i[int'(m_cur.eng)*IW +: IW] : '0;
    chk("mdl_ready", 32'(bus.cmd_ready_o), 32'(m_q.size() < FD));
    chk("mdl_start", 32'(bus.engine_start_o), 32'(xs));
    chk("mdl_param", 32'(bus.engine_param_o), 32'(m_cur.param));
    chk("mdl_instr", 32'(bus.instruction_o), 32'(xi));
    chk("mdl_busy", 32'(bus.busy_o), 32'(m_active || m_q.size() > 0));
    chk("mdl_cmd_done", 32'(bus.cmd_done_o), 32'(m_cdone));
    chk("mdl_err", 32'(bus.err_timeout_o), 32'(m_err));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic [1:0] e, input logic [5:0] p,
                       input logic [3:0] d, input logic c);
    bus.cmd_valid_i   = v;
    bus.cmd_engine_i  = e;
    bus.cmd_param_i   = p;
    bus.engine_done_i = d;
    bus.err_clr_i     = c;
  endtask

  task automatic settle();
    @(negedge clk);
    model_compare();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cycle(input logic v, input logic [1:0] e, input logic [5:0] p,
                       input logic [3:0] d, input logic c);
    drive(v, e, p, d, c);
    settle();
    advance();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          v;
    logic [1:0]    e;
    logic [5:0]    p;
    logic [3:0]    d;
    logic [3:0]    x_start;
    logic [5:0]    x_param;
    logic [IW-1:0] x_instr;
    logic          x_ready;
    logic          x_busy;
    logic          x_cd;
  } vec_t;

  vec_t tbl[14];

  int busy_n;
  bit seen_start;
  bit saw_cd;
  bit hit;
  logic [3:0] rd;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1'b0, 2'd0, 6'd0, 4'd0, 1'b0);
    bus.engine_instr_i = {W3, W2, W1, W0};
    model_reset();

    // Reset values while reset is held.
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.cmd_ready_o), 32'd1);
    chk("rst_start", 32'(bus.engine_start_o), 32'd0);
    chk("rst_param", 32'(bus.engine_param_o), 32'd0);
    chk("rst_instr", 32'(bus.instruction_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_cmd_done", 32'(bus.cmd_done_o), 32'd0);
    chk("rst_err", 32'(bus.err_timeout_o), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single command with done 3 cycles after start, done in IDLE and from
    // other engines ignored, then a dispatch-cycle done chained back-to-back.
    tbl[0]  = '{1'b1, 2'd1, 6'h2A, 4'h0, 4'h0, 6'h00, 21'h0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 2'd0, 6'h00, 4'hF, 4'h0, 6'h00, 21'h0, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 2'd0, 6'h00, 4'h0, 4'h2, 6'h2A, W1,    1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 6'h00, 4'h5, 4'h0, 6'h2A, W1,    1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 6'h00, 4'h0, 4'h0, 6'h2A, W1,    1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, 6'h00, 4'h2, 4'h0, 6'h2A, W1,    1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 2'd0, 6'h00, 4'h0, 4'h0, 6'h2A, 21'h0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 2'd2, 6'h11, 4'h0, 4'h0, 6'h2A, 21'h0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 2'd3, 6'h05, 4'h0, 4'h0, 6'h2A, 21'h0, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 2'd0, 6'h00, 4'h4, 4'h4, 6'h11, W2,    1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 2'd0, 6'h00, 4'h0, 4'h8, 6'h05, W3,    1'b1, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 2'd0, 6'h00, 4'h8, 4'h0, 6'h05, W3,    1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 2'd0, 6'h00, 4'h0, 4'h0, 6'h05, 21'h0, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 2'd0, 6'h00, 4'h0, 4'h0, 6'h05, 21'h0, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, tbl[i].e, tbl[i].p, tbl[i].d, 1'b0);
      settle();
      chk($sformatf("tbl%0d_start", i), 32'(bus.engine_start_o), 32'(tbl[i].x_start));
      chk($sformatf("tbl%0d_param", i), 32'(bus.engine_param_o), 32'(tbl[i].x_param));
      chk($sformatf("tbl%0d_instr", i), 32'(bus.instruction_o), 32'(tbl[i].x_instr));
      chk($sformatf("tbl%0d_ready", i), 32'(bus.cmd_ready_o), 32'(tbl[i].x_ready));
      chk($sformatf("tbl%0d_busy", i), 32'(bus.busy_o), 32'(tbl[i].x_busy));
      chk($sformatf("tbl%0d_cmd_done", i), 32'(bus.cmd_done_o), 32'(tbl[i].x_cd));
      advance();
    end

    // Queue fill behind a stalled engine 2.
    drive(1'b1, 2'd2, 6'd1, 4'h0, 1'b0); settle();
    chk("fill_a_ready", 32'(bus.cmd_ready_o), 32'd1); advance();
    drive(1'b1, 2'd2, 6'd2, 4'h0, 1'b0); settle();
    chk("fill_b_ready", 32'(bus.cmd_ready_o), 32'd1); advance();
    drive(1'b1, 2'd2, 6'd3, 4'h0, 1'b0); settle();
    chk("fill_c_ready", 32'(bus.cmd_ready_o), 32'd1);
    chk("fill_a_start", 32'(bus.engine_start_o), 32'h4); advance();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd2, 6'd4, 4'h0, 1'b0); settle();
      chk("fill_d_stalled", 32'(bus.cmd_ready_o), 32'd0); advance();
    end
    drive(1'b1, 2'd2, 6'd4, 4'h4, 1'b0); settle();
    chk("fill_d_still_full", 32'(bus.cmd_ready_o), 32'd0); advance();
    drive(1'b1, 2'd2, 6'd4, 4'h4, 1'b0); settle();
    chk("fill_d_accepted", 32'(bus.cmd_ready_o), 32'd1);
    chk("fill_b_param", 32'(bus.engine_param_o), 32'd2); advance();
    drive(1'b0, 2'd0, 6'd0, 4'h4, 1'b0); settle();
    chk("fill_c_param", 32'(bus.engine_param_o), 32'd3);
    chk("fill_c_start", 32'(bus.engine_start_o), 32'h4); advance();
    drive(1'b0, 2'd0, 6'd0, 4'h4, 1'b0); settle();
    chk("fill_d_param", 32'(bus.engine_param_o), 32'd4); advance();
    drive(1'b0, 2'd0, 6'd0, 4'h0, 1'b0); settle();
    chk("fill_drained", 32'(bus.busy_o), 32'd0); advance();

    // Engine 1 never finishes; clear requested in the abort cycle loses.
    cycle(1'b1, 2'd1, 6'h07, 4'h0, 1'b0);
    cycle(1'b1, 2'd0, 6'h08, 4'h0, 1'b0);
    busy_n = 0; seen_start = 1'b0; saw_cd = 1'b0; hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 2'd0, 6'd0, 4'h0, (busy_n == TO - 1));
      settle();
      if (bus.cmd_done_o) saw_cd = 1'b1;
      if (bus.engine_start_o == 4'b0010) seen_start = 1'b1;
      else if (seen_start && bus.instruction_o == W1) busy_n++;
      advance();
      if (bus.err_timeout_o) begin hit = 1'b1; break; end
    end
    chk("tmo_busy_cycles", 32'(busy_n), 32'd15);
    chk("tmo_err_set_wins", 32'(hit), 32'd1);
    chk("tmo_no_cmd_done", 32'(saw_cd), 32'd0);
    drive(1'b0, 2'd0, 6'd0, 4'h0, 1'b1); settle();
    chk("tmo_idle_start", 32'(bus.engine_start_o), 32'd0);
    chk("tmo_idle_instr", 32'(bus.instruction_o), 32'd0);
    chk("tmo_err_held", 32'(bus.err_timeout_o), 32'd1);
    advance();
    chk("tmo_err_cleared", 32'(bus.err_timeout_o), 32'd0);
    drive(1'b0, 2'd0, 6'd0, 4'h1, 1'b0); settle();
    chk("tmo_next_start", 32'(bus.engine_start_o), 32'h1);
    chk("tmo_next_param", 32'(bus.engine_param_o), 32'h08);
    chk("tmo_next_instr", 32'(bus.instruction_o), 32'(W0));
    advance();
    drive(1'b0, 2'd0, 6'd0, 4'h0, 1'b0); settle();
    chk("tmo_next_done", 32'(bus.cmd_done_o), 32'd1);
    chk("tmo_next_idle", 32'(bus.busy_o), 32'd0);
    advance();

    // Asynchronous reset in the middle of BUSY with one command queued.
    cycle(1'b1, 2'd3, 6'h21, 4'h0, 1'b0);
    cycle(1'b1, 2'd0, 6'h22, 4'h0, 1'b0);
    cycle(1'b0, 2'd0, 6'h00, 4'h0, 1'b0);
    cycle(1'b0, 2'd0, 6'h00, 4'h0, 1'b0);
    chk("pre_rst_busy", 32'(bus.busy_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", 32'(bus.cmd_ready_o), 32'd1);
    chk("arst_start", 32'(bus.engine_start_o), 32'd0);
    chk("arst_param", 32'(bus.engine_param_o), 32'd0);
    chk("arst_instr", 32'(bus.instruction_o), 32'd0);
    chk("arst_busy", 32'(bus.busy_o), 32'd0);
    chk("arst_cmd_done", 32'(bus.cmd_done_o), 32'd0);
    chk("arst_err", 32'(bus.err_timeout_o), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'd0, 6'd0, 4'h0, 1'b0); settle();
      chk("post_rst_busy", 32'(bus.busy_o), 32'd0);
      chk("post_rst_start", 32'(bus.engine_start_o), 32'd0);
      advance();
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NE; k++) rd[k] = ($urandom_range(0, 3) == 0);
      bus.engine_instr_i = (NE*IW)'({$urandom(), $urandom(), $urandom()});
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            6'($urandom_range(0, 63)), rd, ($urandom_range(0, 19) == 0));
      settle();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
